// File: rtl/uram_read_streamer_pkg.sv
// -----------------------------------------------------------------------------
// uram_read_streamer_pkg
//   Shared definitions for the URAM read streamer:
//     state_e - streamer FSM state encoding
//     lat_f   - RAM read latency (cycles from address to captured data) as a
//               function of the RAM output pipeline depth.
// -----------------------------------------------------------------------------
package uram_read_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One cycle for the array access, one for the memory latch, plus the
  // configurable output register stages.
  function automatic int lat_f(input int nbpipe);
    return nbpipe + 2;
  endfunction

endpackage

// File: rtl/uram_rd_fifo.sv
// -----------------------------------------------------------------------------
// uram_rd_fifo
//   Synchronous skid FIFO between the RAM read pipeline and the output stream.
//   Entries are {last, data}. Push and pop in the same cycle are accepted at
//   any occupancy (when full, the pop frees the slot the push uses).
//   Ports:
//     core_clk, resetn   - clock, synchronous active-low reset
//     push_i, wdata_i    - write strobe and entry
//     pop_i              - read strobe (ignored when empty)
//     rdata_o            - head entry, forced to zero when empty
//     count_o            - current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uram_rd_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             core_clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

  // Storage carries no reset; empty gating keeps the output clean.
  always_ff @(posedge core_clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = empty ? '0 : mem[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/uram_read_streamer.sv
// -----------------------------------------------------------------------------
// uram_read_streamer
//   Streams a burst of consecutive URAM words onto a valid/ready interface.
//   Reads are issued one per cycle while credits allow; each issued read is
//   tagged in a LAT-deep valid shift register and its data is pushed into a
//   skid FIFO when the tag falls out. Credits (inflight + FIFO occupancy) are
//   bounded by the FIFO depth so no returning word can ever be dropped.
//   Ports:
//     core_clk, resetn             - clock, synchronous active-low reset
//     start, base_addr, length     - burst request (sampled in IDLE only)
//     busy, done                   - burst in progress / completion pulse
//     ram_mem_en, ram_regceb       - RAM enables (high whenever out of reset)
//     ram_addrb, ram_doutb         - RAM read port
//     m_data, m_valid, m_ready,
//     m_last                       - output stream
// -----------------------------------------------------------------------------
module uram_read_streamer
  import uram_read_streamer_pkg::*;
#(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 512,
  parameter int NBPIPE     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              core_clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_mem_en,
  output logic              ram_regceb,
  output logic [AWIDTH-1:0] ram_addrb,
  input  logic [DWIDTH-1:0] ram_doutb,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int LAT = lat_f(NBPIPE);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH:0]   rem_q;
  logic [LAT-1:0]    vld_sr_q, lst_sr_q;
  logic [CW-1:0]     infl_q, infl_d;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       credit_sum;
  logic              iss, final_iss, push, pop;
  logic [DWIDTH:0]   fifo_rdata;

  // ram_addrb always holds the next address; a read is issued in any ISSUE
  // cycle where the outstanding words would still fit in the FIFO.
  assign credit_sum = {1'b0, infl_q} + {1'b0, fifo_cnt};
  assign iss        = (state_q == ST_ISSUE) && (credit_sum < (CW + 1)'(FIFO_DEPTH));
  assign final_iss  = iss && (rem_q == (AWIDTH + 1)'(1));
  assign push       = vld_sr_q[LAT-1];
  assign pop        = m_valid & m_ready;
  assign infl_d     = infl_q + CW'(iss) - CW'(push);

  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      vld_sr_q <= '0;
      lst_sr_q <= '0;
      infl_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      vld_sr_q <= {vld_sr_q[LAT-2:0], iss};
      lst_sr_q <= {lst_sr_q[LAT-2:0], final_iss};
      infl_q   <= infl_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= base_addr;
              rem_q   <= length;
              busy_q  <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (iss) begin
            addr_q <= addr_q + AWIDTH'(1);
            rem_q  <= rem_q - (AWIDTH + 1)'(1);
            if (final_iss) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM returns data LAT cycles after the address; the tag and the last flag
  // leave their shift registers exactly when that word is on ram_doutb.
  uram_rd_fifo #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .core_clk (core_clk),
    .resetn   (resetn),
    .push_i   (push),
    .wdata_i  ({lst_sr_q[LAT-1], ram_doutb}),
    .pop_i    (pop),
    .rdata_o  (fifo_rdata),
    .count_o  (fifo_cnt)
  );

  assign ram_mem_en = resetn;
  assign ram_regceb = resetn;
  assign ram_addrb  = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign m_valid    = (fifo_cnt != '0);
  assign m_data     = fifo_rdata[DWIDTH-1:0];
  assign m_last     = fifo_rdata[DWIDTH];

endmodule

// File: tb/tb_uram_read_streamer.sv
module tb_uram_read_streamer;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NBP = 1;
  localparam int FD  = 8;

  logic          core_clk = 1'b0;
  logic          resetn   = 1'b0;
  logic          start    = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length    = '0;
  logic          busy, done, ram_mem_en, ram_regceb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb, m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  uram_read_streamer #(
    .AWIDTH(AW), .DWIDTH(DW), .NBPIPE(NBP), .FIFO_DEPTH(FD)
  ) dut (
    .core_clk   (core_clk),
    .resetn     (resetn),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_mem_en (ram_mem_en),
    .ram_regceb (ram_regceb),
    .ram_addrb  (ram_addrb),
    .ram_doutb  (ram_doutb),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  // RAM model: mem[i] = i, address seen in cycle t appears in cycle t+LAT.
  logic [AW-1:0] rpipe [0:NBP+1];
  always @(posedge core_clk) begin
    rpipe[0] <= ram_addrb;
    for (int k = 1; k < NBP + 2; k++) rpipe[k] <= rpipe[k-1];
  end
  assign ram_doutb = DW'(rpipe[NBP+1]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream monitor
  logic [31:0] beats[$];
  bit          lasts[$];
  int          done_cnt = 0;
  bit          valid_seen = 0;
  int          first_busy_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  bit          stab_en = 0, prev_stall = 0;
  logic [31:0] prev_data = '0;

  always @(negedge core_clk) begin
    if (resetn) begin
      if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
      if (m_valid) begin
        valid_seen = 1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        beats.push_back(m_data);
        lasts.push_back(m_last);
        if (m_last) last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stab_en && prev_stall) check("stall_hold", m_data, prev_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic clear_mon();
    beats.delete();
    lasts.delete();
    done_cnt = 0;
    valid_seen = 0;
    first_busy_cyc = -1;
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic do_start(input int b, input int l);
    @(posedge core_clk); #1;
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW + 1)'(l);
    @(posedge core_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge core_clk);
    repeat (10) @(posedge core_clk);
    #1;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic check_beats(input string tag, input int b, input int n);
    check({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      check({tag, "_data"}, beats[i], (b + i) % 4096);
      check({tag, "_last"}, lasts[i], (i == n - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge core_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", ram_addrb, 0);
    check("rst_mem_en", ram_mem_en, 0);
    check("rst_regceb", ram_regceb, 0);
    resetn = 1'b1;
    @(posedge core_clk); #1;
    check("run_mem_en", ram_mem_en, 1);
    check("run_regceb", ram_regceb, 1);

    // Basic burst, full throughput
    clear_mon();
    m_ready = 1'b1;
    do_start(5, 4);
    wait_done("t1", 100);
    check_beats("t1", 5, 4);
    check("t1_first_valid_lat", first_valid_cyc - first_busy_cyc, 4);
    check("t1_throughput", last_hs_cyc - first_valid_cyc, 3);
    check("t1_done_delay", done_cyc - last_hs_cyc, 1);

    // Address wrap
    clear_mon();
    do_start(4094, 4);
    wait_done("t2", 100);
    check_beats("t2", 4094, 4);

    // Long stall: credits must stop issue at FIFO depth
    clear_mon();
    m_ready = 1'b0;
    do_start(100, 20);
    repeat (50) @(posedge core_clk);
    #1;
    check("t3_issued_in_stall", ram_addrb, 100 + FD);
    check("t3_valid_in_stall", m_valid, 1);
    check("t3_busy_in_stall", busy, 1);
    m_ready = 1'b1;
    wait_done("t3", 200);
    check_beats("t3", 100, 20);

    // Random backpressure at 30% ready
    clear_mon();
    stab_en = 1;
    do_start(200, 16);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(posedge core_clk); #1;
      m_ready = ($urandom_range(0, 99) < 30);
    end
    stab_en = 0;
    m_ready = 1'b1;
    wait_done("t4", 10);
    check_beats("t4", 200, 16);

    // Zero length burst
    clear_mon();
    do_start(33, 0);
    check("t5_done_pulse", done, 1);
    check("t5_busy", busy, 0);
    repeat (6) @(posedge core_clk);
    #1;
    check("t5_done_cnt", done_cnt, 1);
    check("t5_no_valid", valid_seen, 0);

    // Start while busy is ignored
    clear_mon();
    do_start(10, 3);
    @(posedge core_clk); #1;
    start = 1'b1;
    base_addr = AW'(500);
    length = (AW + 1)'(5);
    @(posedge core_clk); #1;
    start = 1'b0;
    wait_done("t6", 100);
    check_beats("t6", 10, 3);

    // Reset in the middle of a burst
    clear_mon();
    do_start(300, 10);
    for (int i = 0; i < 100 && beats.size() < 3; i++) @(posedge core_clk);
    #1;
    resetn = 1'b0;
    @(posedge core_clk); #1;
    check("t7_rst_valid", m_valid, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_last", m_last, 0);
    check("t7_rst_data", m_data, 0);
    check("t7_rst_addr", ram_addrb, 0);
    check("t7_rst_mem_en", ram_mem_en, 0);
    @(posedge core_clk); #1;
    resetn = 1'b1;
    repeat (10) @(posedge core_clk);
    #1;
    check("t7_no_done", done_cnt, 0);
    check("t7_beats_before_rst", beats.size(), 3);
    check("t7_late_data_dropped", m_valid, 0);
    clear_mon();
    do_start(7, 2);
    wait_done("t8", 100);
    check_beats("t8", 7, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uram_read_streamer.md
URAM_READ_STREAMER -- requirements
Module: uram_read_streamer

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, RAM address width.
REQ-002 SHALL have parameter DWIDTH, default 512, RAM data width.
REQ-003 SHALL have parameter NBPIPE, default 1, RAM output pipeline depth, >=1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, skid FIFO entries, power of two, >= NBPIPE+2.
REQ-005 core_clk  in  1  clock; all logic on rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to stream a burst; sampled only in IDLE.
REQ-008 base_addr  in  AWIDTH  first read address, latched on accepted start.
REQ-009 length  in  AWIDTH+1  beat count, 0..2^AWIDTH, latched on accepted start.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse at burst completion.
REQ-012 ram_mem_en  out  1  RAM memory enable; constant 1 out of reset.
REQ-013 ram_regceb  out  1  RAM output register enable; constant 1 out of reset.
REQ-014 ram_addrb  out  AWIDTH  RAM read address.
REQ-015 ram_doutb  in  DWIDTH  RAM read data.
REQ-016 m_data  out  DWIDTH  stream data.
REQ-017 m_valid  out  1  stream valid.
REQ-018 m_ready  in  1  stream ready.
REQ-019 m_last  out  1  high with the final beat of a burst.

Function
REQ-020 Read latency SHALL be LAT = NBPIPE+2: data for an address on ram_addrb in cycle t is captured from ram_doutb in cycle t+LAT.
REQ-021 FSM states: IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-022 IDLE: start with length>0 -> ISSUE; start with length=0 -> IDLE, done pulses next cycle, no beats; start ignored in ISSUE/DRAIN.
REQ-023 ISSUE: one read per cycle when inflight+fifo_count < FIFO_DEPTH; address increments by 1 per issued read and wraps 2^AWIDTH-1 -> 0.
REQ-024 ISSUE -> DRAIN in the cycle the final read issues.
REQ-025 DRAIN -> IDLE with done pulse in the cycle after the final beat handshake (m_valid & m_ready & m_last).
REQ-026 A LAT-deep valid shift register SHALL tag issued reads; tagged data SHALL be written to the skid FIFO and never dropped.
REQ-027 The credit rule SHALL guarantee no FIFO overflow under any m_ready pattern, including m_ready held low indefinitely.
REQ-028 With m_ready=1 continuously, throughput SHALL be one beat per cycle after the first LAT cycles.
REQ-029 m_valid SHALL equal FIFO non-empty; m_data and m_last SHALL hold stable while m_valid & !m_ready.
REQ-030 Simultaneous FIFO push and pop SHALL be allowed when full or empty, and occupancy SHALL stay correct.
REQ-031 length=2^AWIDTH SHALL read every address exactly once, starting from base_addr.

Reset
REQ-032 resetn low SHALL give: state IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, ram_addrb=0, FIFO empty, inflight=0, valid shift register cleared.
REQ-033 Reset mid-burst SHALL abort the burst with no done pulse; late RAM data SHALL be discarded.
REQ-034 ram_mem_en and ram_regceb SHALL be 0 during reset and 1 otherwise.

Structure
REQ-035 A shared package SHALL hold the state encoding and a LAT function of NBPIPE.
REQ-036 The skid FIFO SHALL be sub-module uram_rd_fifo: synchronous, DWIDTH+1 wide (data plus last), FIFO_DEPTH deep, with count output.
REQ-037 Credit counter, address counter and valid shift register SHALL live in the top module.

Verification
REQ-038 NBPIPE=1, RAM preloaded mem[i]=i, start base=5 len=4, m_ready=1 -> beats 5,6,7,8; first m_valid 4 cycles after first issue; m_last on 8; done next cycle.
REQ-039 base=4094 len=4, AWIDTH=12 -> beats 4094,4095,0,1.
REQ-040 len=20, m_ready=0 for 50 cycles then 1 -> exactly FIFO_DEPTH reads issued while stalled; no overflow; all 20 beats in order.
REQ-041 len=16, random m_ready at 30% -> in-order data, m_data stable while stalled, one m_last, one done.
REQ-042 len=0 -> done pulse 1 cycle after start, m_valid never asserted; start during busy -> ignored.
REQ-043 resetn low at beat 3 of len=10 -> outputs reset values next cycle, no done; new burst len=2 after reset -> correct 2 beats.
